// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer for the LC3 pipeline: redirect arbitration with stage
// flushes, plus the interrupt entry sequence (drain, save return PC, vector, ack).
module pc_redirect_ctrl #(
  parameter logic [15:0] RESET_PC     = 16'h3000,
  parameter logic [7:0]  VEC_BASE     = 8'h01,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        id_redir,
  input  logic [15:0] id_target,
  input  logic        ex_redir,
  input  logic [15:0] ex_target,
  input  logic        mem_redir,
  input  logic [15:0] mem_target,
  input  logic        int_req,
  input  logic [7:0]  int_vector,
  output logic [15:0] fetch_pc,
  output logic        fetch_valid,
  output logic        idCond,
  output logic        exCond,
  output logic        memCond,
  output logic        intCond,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [15:0] saved_pc,
  output logic        int_ack
);

  typedef enum logic [1:0] {RUN, DRAIN, VECTOR} state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  vec, vec_nxt;
  logic [15:0] pc_nxt, saved_nxt, redir_pc, seq_pc;
  logic        valid_nxt, ack_nxt, redir_en, any_redir;

  // Redirects are honoured in RUN and DRAIN; VECTOR owns the PC mux.
  assign redir_en  = (state != VECTOR);
  assign any_redir = mem_redir | ex_redir | id_redir;
  assign redir_pc  = mem_redir ? mem_target : (ex_redir ? ex_target : id_target);
  assign seq_pc    = (imem_ready & ~stall) ? fetch_pc + 16'd1 : fetch_pc;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vec_nxt   = vec;
    pc_nxt    = fetch_pc;
    saved_nxt = saved_pc;
    valid_nxt = fetch_valid;
    ack_nxt   = 1'b0;

    memCond  = redir_en & mem_redir;
    exCond   = redir_en & ex_redir & ~mem_redir;
    idCond   = redir_en & id_redir & ~ex_redir & ~mem_redir;
    intCond  = (state == VECTOR);
    flush_if = (redir_en & any_redir) | intCond;
    flush_id = redir_en & (mem_redir | ex_redir);
    flush_ex = redir_en & mem_redir;

    case (state)
      RUN: begin
        if (any_redir) begin
          pc_nxt = redir_pc;
        end else begin
          pc_nxt = seq_pc;
          if (int_req) begin
            vec_nxt   = int_vector;
            saved_nxt = seq_pc;
            valid_nxt = 1'b0;
            cnt_nxt   = DRAIN_INIT;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // A late redirect changes where the interrupted program resumes.
        if (any_redir) saved_nxt = redir_pc;
        if (cnt == 4'd0) state_nxt = VECTOR;
        else             cnt_nxt   = cnt - 4'd1;
      end
      VECTOR: begin
        pc_nxt    = {VEC_BASE, vec};
        valid_nxt = 1'b1;
        ack_nxt   = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= 4'd0;
      vec         <= 8'd0;
      fetch_pc    <= RESET_PC;
      fetch_valid <= 1'b1;
      saved_pc    <= 16'd0;
      int_ack     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      vec         <= vec_nxt;
      fetch_pc    <= pc_nxt;
      fetch_valid <= valid_nxt;
      saved_pc    <= saved_nxt;
      int_ack     <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: sequential fetch, redirect priority,
// stall interaction, wrap, interrupt entry, drain-time redirect and abort by reset.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, imem_ready;
  logic        id_redir, ex_redir, mem_redir, int_req;
  logic [15:0] id_target, ex_target, mem_target;
  logic [7:0]  int_vector;
  logic [15:0] fetch_pc, saved_pc;
  logic        fetch_valid, int_ack;
  logic        idCond, exCond, memCond, intCond, flush_if, flush_id, flush_ex;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
    .id_redir(id_redir), .id_target(id_target),
    .ex_redir(ex_redir), .ex_target(ex_target),
    .mem_redir(mem_redir), .mem_target(mem_target),
    .int_req(int_req), .int_vector(int_vector),
    .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .idCond(idCond), .exCond(exCond), .memCond(memCond), .intCond(intCond),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
    .saved_pc(saved_pc), .int_ack(int_ack)
  );

  // {idCond, exCond, memCond, intCond, flush_if, flush_id, flush_ex}
  logic [6:0] sel;
  assign sel = {idCond, exCond, memCond, intCond, flush_if, flush_id, flush_ex};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_redir = 0; ex_redir = 0; mem_redir = 0; int_req = 0;
  endtask

  task automatic go_to(input logic [15:0] pc);
    mem_redir = 1; mem_target = pc;
    tick();
    mem_redir = 0;
  endtask

  // Accept an interrupt with vector x80 from fetch_pc x3010 (returns to x3011).
  task automatic enter_int();
    go_to(16'h3010);
    int_req = 1; int_vector = 8'h80;
    tick();
    int_req = 0;
  endtask

  initial begin
    reset = 1; stall = 0; imem_ready = 0; idle();
    id_target = 0; ex_target = 0; mem_target = 0; int_vector = 0;
    #12;
    chk("rst_pc", fetch_pc, 16'h3000);
    chk("rst_valid", fetch_valid, 1);
    chk("rst_saved", saved_pc, 0);
    chk("rst_ack", int_ack, 0);
    chk("rst_sel", sel, 7'b0);
    reset = 0;

    // Sequential fetch
    imem_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      #1 chk("seq_sel", sel, 7'b0);
      tick();
      chk("seq_pc", fetch_pc, 16'h3000 + 16'(i));
    end

    // Three simultaneous redirects: MEM wins
    id_redir = 1; id_target = 16'h4000;
    ex_redir = 1; ex_target = 16'h5000;
    mem_redir = 1; mem_target = 16'h6000;
    #1 chk("pri_sel", sel, 7'b0010111);
    tick();
    chk("pri_pc", fetch_pc, 16'h6000);
    idle();

    // EX redirect under stall
    stall = 1; ex_redir = 1; ex_target = 16'h1234;
    #1 chk("stall_ex_sel", sel, 7'b0100110);
    tick();
    chk("stall_ex_pc", fetch_pc, 16'h1234);
    idle();
    tick();
    chk("stall_hold", fetch_pc, 16'h1234);

    // ID-only redirect with imem not ready
    stall = 0; imem_ready = 0; id_redir = 1; id_target = 16'h0042;
    #1 chk("id_sel", sel, 7'b1000100);
    tick();
    chk("id_pc", fetch_pc, 16'h0042);
    idle();
    tick();
    chk("nordy_hold", fetch_pc, 16'h0042);
    imem_ready = 1;

    // Wrap xFFFF -> x0000
    go_to(16'hFFFF);
    chk("wrap_pre", fetch_pc, 16'hFFFF);
    tick();
    chk("wrap_pc", fetch_pc, 16'h0000);

    // Interrupt entry
    enter_int();
    chk("int_saved", saved_pc, 16'h3011);
    chk("int_valid0", fetch_valid, 0);
    for (int i = 0; i < 2; i++) begin
      chk("drain_sel", sel, 7'b0);
      tick();
      chk("drain_valid", fetch_valid, 0);
      chk("drain_pc", fetch_pc, 16'h3011);
    end
    tick();
    chk("vec_sel", sel, 7'b0001100);
    chk("vec_ack0", int_ack, 0);
    tick();
    chk("vec_pc", fetch_pc, 16'h0180);
    chk("vec_ack", int_ack, 1);
    chk("vec_valid", fetch_valid, 1);
    chk("vec_saved", saved_pc, 16'h3011);
    chk("vec_sel_run", sel, 7'b0);
    tick();
    chk("ack_pulse", int_ack, 0);
    chk("post_vec_pc", fetch_pc, 16'h0181);

    // MEM redirect during DRAIN, then an ignored EX redirect in VECTOR
    enter_int();
    mem_redir = 1; mem_target = 16'h2000;
    #1 chk("drain_redir_sel", sel, 7'b0010111);
    tick();
    idle();
    chk("drain_redir_saved", saved_pc, 16'h2000);
    chk("drain_redir_pc", fetch_pc, 16'h3011);
    tick();
    tick();
    ex_redir = 1; ex_target = 16'h7777;
    #1 chk("vec_ignore_sel", sel, 7'b0001100);
    tick();
    idle();
    chk("vec2_pc", fetch_pc, 16'h0180);
    chk("vec2_ack", int_ack, 1);
    chk("vec2_saved", saved_pc, 16'h2000);

    // Reset in the middle of DRAIN
    tick();
    enter_int();
    tick();
    #2 reset = 1;
    #1;
    chk("abort_pc", fetch_pc, 16'h3000);
    chk("abort_valid", fetch_valid, 1);
    chk("abort_saved", saved_pc, 0);
    chk("abort_sel", sel, 7'b0);
    #4 reset = 0;
    imem_ready = 0;
    begin
      int acks = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (int_ack) acks++;
      end
      chk("abort_no_ack", acks, 0);
      chk("abort_pc_hold", fetch_pc, 16'h3000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
